// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and widths for the SPI byte shifter
package spi_pkg;

  localparam int SPI_BITS  = 8;
  localparam int SPI_CNT_W = $clog2(SPI_BITS);

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    SHIFT,
    DONE
  } spi_state_t;

endpackage

// File: rtl/spi_byte_shifter_edge_detector.sv
// rtl/spi_byte_shifter_edge_detector.sv - rise/fall strobes for a level produced in the same clock domain
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic level_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  // Source is already synchronous to clock, so no synchroniser stage.
  assign rise = level & ~level_q;
  assign fall = ~level & level_q;

endmodule

// File: rtl/spi_byte_shifter.sv
// rtl/spi_byte_shifter.sv - mode-0 MSB-first SPI byte master timed by divided_clock; SPI_SHIFTER_CS_HOLD_EN chains bytes in one CS frame
module spi_byte_shifter
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_BITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  divided_clock,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n
);

  localparam int              CW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(DATA_WIDTH - 1);

  spi_state_t            state;
  logic [DATA_WIDTH-2:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [CW-1:0]         count;
  logic                  rise;
  logic                  fall;

  edge_detector u_edge (
    .clock (clock),
    .reset (reset),
    .level (divided_clock),
    .rise  (rise),
    .fall  (fall)
  );

  // tx_sr holds only the bits not yet on mosi; the MSB goes straight to mosi on load.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      tx_sr    <= '0;
      rx_sr    <= '0;
      count    <= '0;
      tx_ready <= 1'b1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= 1'b1;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            tx_sr    <= tx_data[DATA_WIDTH-2:0];
            mosi     <= tx_data[DATA_WIDTH-1];
            cs_n     <= 1'b0;
            count    <= '0;
            tx_ready <= 1'b0;
            state    <= LEAD;
          end
        end

        LEAD: begin
          if (fall) begin
            state <= SHIFT;
          end
        end

        SHIFT: begin
          if (rise) begin
            sclk  <= 1'b1;
            rx_sr <= {rx_sr[DATA_WIDTH-2:0], miso};
          end else if (fall) begin
            sclk <= 1'b0;
            if (count == LAST) begin
              state <= DONE;
`ifdef SPI_SHIFTER_CS_HOLD_EN
              tx_ready <= 1'b1;
`endif
            end else begin
              tx_sr <= tx_sr << 1;
              mosi  <= tx_sr[DATA_WIDTH-2];
              count <= count + 1'b1;
            end
          end
        end

        DONE: begin
          rx_valid <= 1'b1;
          rx_data  <= rx_sr;
`ifdef SPI_SHIFTER_CS_HOLD_EN
          // The last fall just happened, so the next rise is bit 7 of the new byte.
          if (tx_valid) begin
            tx_sr    <= tx_data[DATA_WIDTH-2:0];
            mosi     <= tx_data[DATA_WIDTH-1];
            count    <= '0;
            tx_ready <= 1'b0;
            state    <= SHIFT;
          end else begin
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
            tx_ready <= 1'b1;
            state    <= IDLE;
          end
`else
          cs_n     <= 1'b1;
          mosi     <= 1'b0;
          tx_ready <= 1'b1;
          state    <= IDLE;
`endif
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_shifter.sv
// tb/tb_spi_byte_shifter.sv - randomized self-checking bench for spi_byte_shifter with a timestamp-level model
module tb_spi_byte_shifter;

  localparam int HMAX = 8192;
`ifdef SPI_SHIFTER_CS_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic       divided_clock;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       cs_n;
  logic       miso_drv;
  logic       loop_en;
  logic       rand_miso;

  assign miso = loop_en ? mosi : miso_drv;

  spi_byte_shifter dut (
    .clock         (clock),
    .reset         (reset),
    .divided_clock (divided_clock),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .sclk          (sclk),
    .mosi          (mosi),
    .miso          (miso),
    .cs_n          (cs_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Inputs as seen at posedge index t.
  logic       dc_h   [HMAX];
  logic       txv_h  [HMAX];
  logic       rst_h  [HMAX];
  logic       miso_h [HMAX];
  logic [7:0] txd_h  [HMAX];
  int t_drv = 0;
  int h_cur = 3;
  int ph_base = 0;

  // Monitor results, written only by the compare process.
  int         mon_rises = 0, mon_frames = 0, mon_rxv = 0, mon_mosi_ones = 0;
  int         mon_last_rise_t = 0, mon_prev_rise_t = 0, mon_dc_rise_t = 0, mon_lag = 0;
  logic [7:0] mon_mosi = 8'h00;
  logic [7:0] mon_rx_hist [64];

  // Model of the current frame: timestamps of every SCLK edge plus the byte.
  logic       m_on = 1'b0;
  int         m_r [8];
  int         m_f [8];
  logic [7:0] m_b, m_rx, m_rxd;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp(input string name, input int t, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  function automatic logic dc_at(input int x);
    return logic'(((x - ph_base) / h_cur) % 2);
  endfunction

  function automatic logic dcv(input int x, input int now);
    return (x <= now) ? dc_h[x] : dc_at(x);
  endfunction

  function automatic int next_edge(input int from, input logic want_rise, input int now);
    for (int x = from + 1; x < from + 200; x++) begin
      if (dcv(x, now) == want_rise && dcv(x - 1, now) == !want_rise) return x;
    end
    return from + 100000;
  endfunction

  task automatic start_frame(input int e0, input logic [7:0] b, input int now);
    int prev;
    m_on = 1'b1;
    m_b  = b;
    m_rx = 8'h00;
    prev = e0;
    for (int i = 0; i < 8; i++) begin
      m_r[i] = next_edge(prev, 1'b1, now);
      m_f[i] = next_edge(m_r[i], 1'b0, now);
      prev   = m_f[i];
    end
  endtask

  // Compare process: model advanced one posedge at a time, DUT sampled 1 ns later.
  initial begin : compare
    int t, k, f8;
    logic e_cs, e_sclk, e_mosi, e_rdy, e_rxv;
    logic p_sclk, p_cs;
    p_sclk = 1'b0;
    p_cs   = 1'b1;
    m_rxd  = 8'h00;
    forever begin
      @(posedge clock);
      #1;
      t     = t_drv;
      e_rxv = 1'b0;
      if (rst_h[t]) begin
        m_on  = 1'b0;
        m_rxd = 8'h00;
      end else if (m_on && t == m_f[7] + 1) begin
        e_rxv = 1'b1;
        m_rxd = m_rx;
        m_on  = 1'b0;
        f8    = m_f[7];
        if (HOLD && txv_h[t]) start_frame(f8, txd_h[t], t);
      end else if (!m_on && txv_h[t]) begin
        start_frame(next_edge(t, 1'b0, t), txd_h[t], t);
      end
      if (m_on) begin
        for (int i = 0; i < 8; i++) if (m_r[i] == t) m_rx[7-i] = miso_h[t];
        k = 0;
        for (int i = 0; i < 7; i++) if (m_f[i] <= t) k++;
        e_sclk = 1'b0;
        for (int i = 0; i < 8; i++) if (m_r[i] <= t && t < m_f[i]) e_sclk = 1'b1;
        e_cs   = 1'b0;
        e_mosi = m_b[7-k];
        e_rdy  = HOLD && (t == m_f[7]);
      end else begin
        e_cs   = 1'b1;
        e_sclk = 1'b0;
        e_mosi = 1'b0;
        e_rdy  = 1'b1;
      end
      cmp("cs_n", t, {7'd0, cs_n}, {7'd0, e_cs});
      cmp("sclk", t, {7'd0, sclk}, {7'd0, e_sclk});
      cmp("mosi", t, {7'd0, mosi}, {7'd0, e_mosi});
      cmp("tx_ready", t, {7'd0, tx_ready}, {7'd0, e_rdy});
      cmp("rx_valid", t, {7'd0, rx_valid}, {7'd0, e_rxv});
      cmp("rx_data", t, rx_data, m_rxd);

      // divided_clock stands in for a register that updated just after the previous edge.
      if (t > 0 && dc_h[t] && !dc_h[t-1]) mon_dc_rise_t = t - 1;
      if (sclk === 1'b1 && p_sclk === 1'b0) begin
        mon_rises++;
        mon_mosi        = {mon_mosi[6:0], mosi};
        mon_prev_rise_t = mon_last_rise_t;
        mon_last_rise_t = t;
        mon_lag         = t - mon_dc_rise_t;
      end
      if (cs_n === 1'b0 && p_cs === 1'b1) mon_frames++;
      if (cs_n === 1'b0 && mosi === 1'b1) mon_mosi_ones++;
      if (rx_valid === 1'b1) begin
        mon_rx_hist[mon_rxv % 64] = rx_data;
        mon_rxv++;
      end
      p_sclk = sclk;
      p_cs   = cs_n;
    end
  end

  task automatic tick();
    if (rand_miso) miso_drv = 1'($urandom_range(0, 1));
    divided_clock  = dc_at(t_drv);
    dc_h[t_drv]    = divided_clock;
    txv_h[t_drv]   = tx_valid;
    txd_h[t_drv]   = tx_data;
    rst_h[t_drv]   = reset;
    miso_h[t_drv]  = loop_en ? mosi : miso_drv;
    @(negedge clock);
    t_drv++;
    if (t_drv >= HMAX - 2) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", t_drv, HMAX - 2);
      $fatal(1);
    end
  endtask

  task automatic set_div(input int d);
    h_cur   = d + 1;
    ph_base = t_drv;
    repeat (4 * (d + 1)) tick();
  endtask

  task automatic send(input logic [7:0] b, input bit drop);
    int g = 0;
    tx_valid = 1'b1;
    tx_data  = b;
    while (tx_ready !== 1'b1 && g < 3000) begin
      tick();
      g++;
    end
    if (g >= 3000) chk("send_timeout", g, 0);
    tick();
    if (drop) begin
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
    end
  endtask

  task automatic wait_rx(input int target);
    int g = 0;
    while (mon_rxv < target && g < 3000) begin
      tick();
      g++;
    end
    if (g >= 3000) chk("rx_valid_timeout", mon_rxv, target);
  endtask

  task automatic wait_rises(input int target);
    int g = 0;
    while (mon_rises < target && g < 3000) begin
      tick();
      g++;
    end
    if (g >= 3000) chk("sclk_rise_timeout", mon_rises, target);
  endtask

  initial begin : drive
    int r0, v0, f0, o0, n_sent;
    logic [7:0] b;
    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    miso_drv = 1'b0; loop_en = 1'b1; rand_miso = 1'b0;
    divided_clock = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_tx_ready", int'(tx_ready), 1);
    chk("reset_cs_n", int'(cs_n), 1);
    chk("reset_sclk", int'(sclk), 0);
    chk("reset_mosi", int'(mosi), 0);
    chk("reset_rx_valid", int'(rx_valid), 0);
    chk("reset_rx_data", int'(rx_data), 0);
    set_div(2);

    // Loopback 0xA5.
    r0 = mon_rises; v0 = mon_rxv;
    send(8'hA5, 1'b1);
    wait_rx(v0 + 1);
    repeat (4) tick();
    chk("a5_rx", int'(mon_rx_hist[v0 % 64]), 8'hA5);
    chk("a5_mosi_order", int'(mon_mosi), 8'hA5);
    chk("a5_rises", mon_rises - r0, 8);
    chk("a5_pulses", mon_rxv - v0, 1);

    // miso tied high, send 0x00.
    loop_en = 1'b0; miso_drv = 1'b1;
    r0 = mon_rises; v0 = mon_rxv; o0 = mon_mosi_ones;
    send(8'h00, 1'b1);
    wait_rx(v0 + 1);
    repeat (2) tick();
    chk("ff_rx", int'(mon_rx_hist[v0 % 64]), 8'hFF);
    chk("ff_mosi_ones", mon_mosi_ones - o0, 0);
    chk("ff_cs_released", int'(cs_n), 1);
    chk("ff_rises", mon_rises - r0, 8);

    // tx_valid during SHIFT is refused.
    loop_en = 1'b1;
    r0 = mon_rises; v0 = mon_rxv; f0 = mon_frames;
    send(8'h96, 1'b1);
    wait_rises(r0 + 1);
    tx_valid = 1'b1; tx_data = 8'h11;
    repeat (10) begin
      chk("busy_tx_ready", int'(tx_ready), 0);
      tick();
    end
    tx_valid = 1'b0;
    wait_rx(v0 + 1);
    repeat (4) tick();
    chk("busy_rx", int'(mon_rx_hist[v0 % 64]), 8'h96);
    chk("busy_frames", mon_frames - f0, 1);
    chk("busy_pulses", mon_rxv - v0, 1);

    // Back-to-back 0x3C then 0xC3 with tx_valid held.
    r0 = mon_rises; v0 = mon_rxv; f0 = mon_frames;
    send(8'h3C, 1'b0);
    send(8'hC3, 1'b1);
    wait_rx(v0 + 2);
    repeat (4) tick();
    chk("b2b_rx0", int'(mon_rx_hist[v0 % 64]), 8'h3C);
    chk("b2b_rx1", int'(mon_rx_hist[(v0 + 1) % 64]), 8'hC3);
    chk("b2b_rises", mon_rises - r0, 16);
    chk("b2b_frames", mon_frames - f0, HOLD ? 1 : 2);

    // Reset after the 4th sclk rise.
    r0 = mon_rises; v0 = mon_rxv;
    send(8'h77, 1'b1);
    wait_rises(r0 + 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_cs_n", int'(cs_n), 1);
    chk("abort_sclk", int'(sclk), 0);
    chk("abort_tx_ready", int'(tx_ready), 1);
    repeat (60) tick();
    chk("abort_no_rx_valid", mon_rxv - v0, 0);
    send(8'h5A, 1'b1);
    wait_rx(v0 + 1);
    repeat (2) tick();
    chk("after_abort_rx", int'(mon_rx_hist[v0 % 64]), 8'h5A);

    // Divider 5: half period of 6 clocks.
    set_div(5);
    v0 = mon_rxv;
    b = 8'($urandom);
    send(b, 1'b1);
    wait_rx(v0 + 1);
    repeat (2) tick();
    chk("div5_period", mon_last_rise_t - mon_prev_rise_t, 12);
    chk("div5_lag", mon_lag, 1);
    chk("div5_rx", int'(mon_rx_hist[v0 % 64]), int'(b));

    // Random groups: divider, loopback or random miso, chaining and stray tx_valid.
    for (int g = 0; g < 6; g++) begin
      set_div(int'($urandom_range(1, 4)));
      loop_en   = 1'($urandom_range(0, 1));
      rand_miso = !loop_en;
      v0 = mon_rxv;
      n_sent = 0;
      for (int k = 0; k < 4; k++) begin
        bit drop;
        drop = (k == 3) || ($urandom_range(0, 1) == 1);
        send(8'($urandom), drop);
        n_sent++;
        if (drop) begin
          repeat ($urandom_range(0, 6)) tick();
          tx_valid = 1'b1;
          tx_data  = 8'($urandom);
          repeat ($urandom_range(1, 5)) tick();
          tx_valid = 1'b0;
        end
      end
      wait_rx(v0 + n_sent);
      repeat (3) tick();
      chk("rand_pulses", mon_rxv - v0, n_sent);
    end
    rand_miso = 1'b0;

    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
